// File: rtl/shared_reg_arbiter.sv
// Three-requester arbiter for one shared register: round-robin grants, with an optional
// locked burst that holds the grant on one owner for up to LOCK_MAX writes.
module shared_reg_arbiter #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         req,
    input  logic [2:0]         lock,
    input  logic [3*WIDTH-1:0] wdata,
    output logic [2:0]         gnt,
    output logic [WIDTH-1:0]   d,
    output logic               d_chg,
    output logic [1:0]         d_src,
    output logic               busy
);

    localparam int unsigned   CW       = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LockMaxC = CW'(LOCK_MAX);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e        r_state, w_state_nxt;
    logic [1:0]    r_ptr, w_ptr_nxt;
    logic [1:0]    r_owner, w_owner_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;

    logic [WIDTH-1:0] r_d;
    logic             r_d_chg;
    logic [1:0]       r_d_src;

    logic             w_wr;
    logic [1:0]       w_idx;
    logic [1:0]       w_i1, w_i2;
    logic [2:0]       w_gnt;
    logic [WIDTH-1:0] w_wdata;

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign w_i1      = inc3(r_ptr);
    assign w_i2      = inc3(w_i1);
    assign w_cnt_inc = r_cnt + CW'(1);

    // Winner selection: owner only while locked, otherwise first requester from ptr.
    always_comb begin
        w_wr  = 1'b0;
        w_idx = r_ptr;
        if (r_state == StLocked) begin
            w_idx = r_owner;
            w_wr  = req[r_owner];
        end else if (req[r_ptr]) begin
            w_idx = r_ptr;
            w_wr  = 1'b1;
        end else if (req[w_i1]) begin
            w_idx = w_i1;
            w_wr  = 1'b1;
        end else if (req[w_i2]) begin
            w_idx = w_i2;
            w_wr  = 1'b1;
        end
    end

    always_comb begin
        w_gnt = 3'b000;
        if (w_wr && rst_n) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    always_comb begin
        w_wdata = wdata[2*WIDTH +: WIDTH];
        case (w_idx)
            2'd0:    w_wdata = wdata[0 +: WIDTH];
            2'd1:    w_wdata = wdata[WIDTH +: WIDTH];
            default: w_wdata = wdata[2*WIDTH +: WIDTH];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_wr) begin
                    if (lock[w_idx] && (LOCK_MAX > 1)) begin
                        w_state_nxt = StLocked;
                        w_owner_nxt = w_idx;
                        w_cnt_nxt   = CW'(1);
                    end else begin
                        w_ptr_nxt = inc3(w_idx);
                    end
                end
            end
            StLocked: begin
                // Owner idle, lock dropped, or burst limit reached all release the lock.
                if (!w_wr || !lock[r_owner] || (w_cnt_inc == LockMaxC)) begin
                    w_state_nxt = StIdle;
                    w_ptr_nxt   = inc3(r_owner);
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ptr   <= 2'd0;
            r_owner <= 2'd0;
            r_cnt   <= '0;
            r_d     <= '0;
            r_d_chg <= 1'b0;
            r_d_src <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_d_chg <= w_wr && (w_wdata != r_d);
            if (w_wr) begin
                r_d     <= w_wdata;
                r_d_src <= w_idx;
            end
        end
    end

    assign gnt   = w_gnt;
    assign d     = r_d;
    assign d_chg = r_d_chg;
    assign d_src = r_d_src;
    assign busy  = (r_state == StLocked);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: round-robin order, locked bursts, same-value
// writes, burst abandonment and asynchronous reset.
module tb_shared_reg_arbiter;

    localparam int unsigned W = 6;

    logic           clk;
    logic           rst_n;
    logic [2:0]     req;
    logic [2:0]     lock;
    logic [3*W-1:0] wdata;
    logic [2:0]     gnt;
    logic [W-1:0]   d;
    logic           d_chg;
    logic [1:0]     d_src;
    logic           busy;

    int checks;
    int failures;

    shared_reg_arbiter #(.WIDTH(W), .LOCK_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .d     (d),
        .d_chg (d_chg),
        .d_src (d_src),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b111;
        lock  = 3'b000;
        wdata = {6'd5, 6'd4, 6'd3};
        #1;
        checks++;
        if (gnt !== 3'b000) begin
            failures++; $display("FAIL reset_gnt: got %b required 000", gnt);
        end
        checks++;
        if (d !== 6'd0 || d_chg !== 1'b0 || d_src !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got d=%0d chg=%b src=%0d busy=%b required 0,0,0,0",
                     d, d_chg, d_src, busy);
        end
        req = 3'b000;
        #21 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] eg;
        req   = 3'b111;
        lock  = 3'b000;
        wdata = {6'd5, 6'd4, 6'd3};
        for (int k = 0; k < 3; k++) begin
            eg = 3'b001 << k;
            #1;
            checks++;
            if (gnt !== eg) begin
                failures++; $display("FAIL rr_gnt[%0d]: got %b required %b", k, gnt, eg);
            end
            tick();
            checks++;
            if (d !== W'(3 + k) || d_src !== 2'(k) || d_chg !== 1'b1) begin
                failures++;
                $display("FAIL rr_write[%0d]: got d=%0d src=%0d chg=%b required %0d,%0d,1",
                         k, d, d_src, d_chg, 3 + k, k);
            end
        end
        req = 3'b000;
        #1;
        checks++;
        if (gnt !== 3'b000) begin
            failures++; $display("FAIL rr_idle_gnt: got %b required 000", gnt);
        end
        tick();
        checks++;
        if (d_chg !== 1'b0) begin
            failures++; $display("FAIL rr_chg_drop: got %b required 0", d_chg);
        end
    endtask

    task automatic test_lock_max();
        // Move ptr to 1 with one unlocked write by requester 0.
        req   = 3'b001;
        lock  = 3'b000;
        wdata = {6'd0, 6'd0, 6'd1};
        tick();
        req   = 3'b011;
        lock  = 3'b010;
        wdata = {6'd0, 6'd7, 6'd2};
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (gnt !== 3'b010) begin
                failures++; $display("FAIL lock_gnt[%0d]: got %b required 010", k, gnt);
            end
            tick();
            checks++;
            if (d !== 6'd7 || d_src !== 2'd1 || busy !== (k < 7) || d_chg !== (k == 0)) begin
                failures++;
                $display("FAIL lock_burst[%0d]: got d=%0d src=%0d busy=%b chg=%b required 7,1,%b,%b",
                         k, d, d_src, busy, d_chg, k < 7, k == 0);
            end
        end
        req   = 3'b101;
        lock  = 3'b000;
        wdata = {6'd10, 6'd0, 6'd2};
        #1;
        checks++;
        if (gnt !== 3'b100) begin
            failures++; $display("FAIL lock_release_ptr: got %b required 100", gnt);
        end
        tick();
        checks++;
        if (d !== 6'd10 || d_src !== 2'd2) begin
            failures++; $display("FAIL lock_after_r2: got d=%0d src=%0d required 10,2", d, d_src);
        end
        #1;
        checks++;
        if (gnt !== 3'b001) begin
            failures++; $display("FAIL lock_then_r0: got %b required 001", gnt);
        end
        tick();
        checks++;
        if (d !== 6'd2 || d_src !== 2'd0) begin
            failures++; $display("FAIL lock_after_r0: got d=%0d src=%0d required 2,0", d, d_src);
        end
    endtask

    task automatic test_same_value();
        req   = 3'b100;
        lock  = 3'b000;
        wdata = {6'd9, 6'd0, 6'd0};
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (gnt !== 3'b100) begin
                failures++; $display("FAIL same_gnt[%0d]: got %b required 100", k, gnt);
            end
            tick();
            checks++;
            if (d !== 6'd9 || d_src !== 2'd2 || d_chg !== (k == 0)) begin
                failures++;
                $display("FAIL same_write[%0d]: got d=%0d src=%0d chg=%b required 9,2,%b",
                         k, d, d_src, d_chg, k == 0);
            end
        end
    endtask

    task automatic test_drop_mid_burst();
        logic [5:0] v;
        req  = 3'b011;
        lock = 3'b001;
        for (int k = 0; k < 3; k++) begin
            v     = 6'(20 + k);
            wdata = {6'd0, 6'd30, v};
            #1;
            checks++;
            if (gnt !== 3'b001) begin
                failures++; $display("FAIL drop_gnt[%0d]: got %b required 001", k, gnt);
            end
            tick();
            checks++;
            if (d !== v || busy !== 1'b1) begin
                failures++;
                $display("FAIL drop_burst[%0d]: got d=%0d busy=%b required %0d,1", k, d, busy, v);
            end
        end
        // Owner idles; lock/data changes on a non-granted cycle must be ignored.
        req   = 3'b010;
        lock  = 3'b011;
        wdata = {6'd0, 6'd30, 6'd40};
        #1;
        checks++;
        if (gnt !== 3'b000) begin
            failures++; $display("FAIL drop_hold_gnt: got %b required 000", gnt);
        end
        tick();
        checks++;
        if (d !== 6'd22 || busy !== 1'b0 || d_chg !== 1'b0) begin
            failures++;
            $display("FAIL drop_release: got d=%0d busy=%b chg=%b required 22,0,0", d, busy, d_chg);
        end
        lock = 3'b000;
        #1;
        checks++;
        if (gnt !== 3'b010) begin
            failures++; $display("FAIL drop_next_gnt: got %b required 010", gnt);
        end
        tick();
        checks++;
        if (d !== 6'd30 || d_src !== 2'd1) begin
            failures++; $display("FAIL drop_next_write: got d=%0d src=%0d required 30,1", d, d_src);
        end
    endtask

    task automatic test_reset_mid_burst();
        req   = 3'b100;
        lock  = 3'b100;
        wdata = {6'd12, 6'd0, 6'd0};
        tick();
        checks++;
        if (d !== 6'd12 || busy !== 1'b1 || d_src !== 2'd2) begin
            failures++;
            $display("FAIL rstm_setup: got d=%0d busy=%b src=%0d required 12,1,2", d, busy, d_src);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (d !== 6'd0 || busy !== 1'b0 || d_src !== 2'd0 || gnt !== 3'b000) begin
            failures++;
            $display("FAIL rstm_async: got d=%0d busy=%b src=%0d gnt=%b required 0,0,0,000",
                     d, busy, d_src, gnt);
        end
        tick();
        checks++;
        if (d !== 6'd0 || gnt !== 3'b000) begin
            failures++; $display("FAIL rstm_held: got d=%0d gnt=%b required 0,000", d, gnt);
        end
        #3 rst_n = 1'b1;
        req   = 3'b111;
        lock  = 3'b000;
        wdata = {6'd15, 6'd14, 6'd13};
        #1;
        checks++;
        if (gnt !== 3'b001) begin
            failures++; $display("FAIL rstm_first_gnt: got %b required 001", gnt);
        end
        tick();
        checks++;
        if (d !== 6'd13 || d_src !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstm_first_write: got d=%0d src=%0d busy=%b required 13,0,0",
                     d, d_src, busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_round_robin();
        test_lock_max();
        test_same_value();
        test_drop_mid_burst();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, setting the data width of the shared register.
REQ-002 The block SHALL have parameter LOCK_MAX, default 8, setting the maximum number of writes in one locked burst.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: port clk (input, 1 bit), rising-edge clock.
REQ-004 The block SHALL have port rst_n (input, 1 bit), asynchronous active-low reset.
REQ-005 The block SHALL have port req (input, 3 bits), per-requester write request, bit i = requester i.
REQ-006 The block SHALL have port lock (input, 3 bits), per-requester burst-hold request, qualified by req.
REQ-007 The block SHALL have port wdata (input, 3*WIDTH bits), write data, requester i in bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port gnt (output, 3 bits), combinational one-hot-or-zero grant; req[i]&gnt[i] commits a write at the next rising edge.
REQ-009 The block SHALL have port d (output, WIDTH bits), the shared register value.
REQ-010 The block SHALL have port d_chg (output, 1 bit), registered pulse flagging that d changed value.
REQ-011 The block SHALL have port d_src (output, 2 bits), index of the last requester that wrote d.
REQ-012 The block SHALL have port busy (output, 1 bit), high while in LOCKED state.

Function
REQ-013 The block SHALL implement states IDLE and LOCKED, plus a 2-bit round-robin pointer ptr (values 0..2) and a burst counter cnt.
REQ-014 In IDLE, the block SHALL assert gnt for the first requester with req high, searching ptr, ptr+1, ptr+2 (mod 3); gnt = 0 when req = 0.
REQ-015 gnt SHALL never be asserted for a requester whose req is low, and at most one gnt bit SHALL be high.
REQ-016 On each edge with req[i]&gnt[i], d SHALL load wdata slice i and d_src SHALL load i; write latency is one edge.
REQ-017 An IDLE-state write by requester i with lock[i]=0 SHALL set ptr to (i+1) mod 3 and remain IDLE.
REQ-018 An IDLE-state write by requester i with lock[i]=1 SHALL enter LOCKED with owner i and cnt = 1.
REQ-019 In LOCKED, gnt SHALL be asserted only to the owner, and only when req[owner] is high; other requests SHALL wait.
REQ-020 In LOCKED, each owner write SHALL increment cnt.
REQ-021 On an owner write in LOCKED with lock[owner]=0, the block SHALL perform the write, return to IDLE, and set ptr to owner+1 mod 3.
REQ-022 On an owner write in LOCKED that brings cnt to LOCK_MAX, the block SHALL perform the write and force-release to IDLE with ptr = owner+1 mod 3, regardless of lock.
REQ-023 In LOCKED with req[owner] low, the block SHALL perform no write, return to IDLE, and set ptr to owner+1 mod 3.
REQ-024 d_chg SHALL be high for exactly the one cycle following a write edge whose new d differs from the old d.
REQ-025 A write of the current value SHALL update d_src, SHALL leave d_chg low, and SHALL count toward cnt.
REQ-026 busy SHALL equal (state == LOCKED), registered.
REQ-027 Simultaneous requests SHALL resolve only by ptr order; over any 3 consecutive unlocked grants with all req high, each requester SHALL be granted exactly once.
REQ-028 Changes to wdata or lock in cycles without a grant SHALL have no effect.

Reset
REQ-029 rst_n low SHALL immediately, independent of clk, force d=0, d_chg=0, d_src=0, busy=0, state IDLE, ptr=0, cnt=0.
REQ-030 While rst_n is low, gnt SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no further writes; after release, arbitration SHALL restart from ptr=0.
REQ-032 Outputs SHALL be stable and gnt SHALL be valid from the first rising edge after rst_n deasserts.

Verification
REQ-033 Bench: req=3'b111, lock=0, wdata={5,4,3} held 3 edges -> gnt sequence 001,010,100; d = 3,4,5; d_src = 0,1,2; d_chg pulse after each edge.
REQ-034 Bench: requester 1 lock=1, req=1, data 7, with req[0] also high, ptr=1 -> busy=1, gnt stays 010 and d=7 for 8 edges, then forced release, busy=0, ptr=2, requester 0 served after requester 2's turn if requesting.
REQ-035 Bench: requester 2 writes 9 twice in consecutive unlocked grants -> d_chg=1 after the first edge, 0 after the second; d_src=2.
REQ-036 Bench: requester 0 locked, drops req mid-burst after 3 writes -> no write on that edge, IDLE next, ptr=1, pending requester 1 granted.
REQ-037 Bench: rst_n pulsed low between clock edges during a LOCKED burst with d=12 -> d=0, busy=0, d_src=0 immediately, gnt=0 while low, first grant after release follows ptr=0.
